// File: rtl/controle_entradas.sv
// Button front end and run-control FSM for a BCD stopwatch: synchronizes and debounces
// four buttons, turns presses into one-cycle pulses and drives Moore command levels.
module controle_entradas #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_contar,
    input  logic       btn_pausar,
    input  logic       btn_parar,
    input  logic       btn_zerar,
    input  logic [3:0] num_ms,
    input  logic [3:0] num_us,
    input  logic [3:0] num_ds,
    input  logic [3:0] num_cs,
    output logic       resetC,
    output logic       contarC,
    output logic       pausarC,
    output logic       pararC,
    output logic [1:0] estado
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        PARADO   = 2'b00,
        CONTANDO = 2'b01,
        PAUSADO  = 2'b10,
        ZERANDO  = 2'b11
    } state_t;

    // Bit order: 0 contar, 1 pausar, 2 parar, 3 zerar (ascending priority).
    logic [3:0] btn_raw;
    logic [3:0] pulse;

    assign btn_raw = {btn_zerar, btn_parar, btn_pausar, btn_contar};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_btn
            logic          sync1_q, sync2_q;
            logic          deb_q, deb_d, deb_dly_q;
            logic          pulse_q, pulse_d;
            logic [CW-1:0] cnt_q, cnt_d;

            always_comb begin
                deb_d   = deb_q;
                cnt_d   = '0;
                if (sync2_q != deb_q) begin
                    // The Nth consecutive differing cycle accepts the new level.
                    if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                        deb_d = sync2_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                pulse_d = deb_q & ~deb_dly_q;
            end

            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    sync1_q   <= 1'b0;
                    sync2_q   <= 1'b0;
                    deb_q     <= 1'b0;
                    deb_dly_q <= 1'b0;
                    cnt_q     <= '0;
                    pulse_q   <= 1'b0;
                end else begin
                    sync1_q   <= btn_raw[gi];
                    sync2_q   <= sync1_q;
                    deb_q     <= deb_d;
                    deb_dly_q <= deb_q;
                    cnt_q     <= cnt_d;
                    pulse_q   <= pulse_d;
                end
            end

            assign pulse[gi] = pulse_q;
        end
    endgenerate

    logic ev_zerar, ev_parar, ev_pausar, ev_contar;
    logic terminal;

    // Only the highest-priority pulse of a cycle survives.
    assign ev_zerar  = pulse[3];
    assign ev_parar  = pulse[2] & ~pulse[3];
    assign ev_pausar = pulse[1] & ~pulse[2] & ~pulse[3];
    assign ev_contar = pulse[0] & ~pulse[1] & ~pulse[2] & ~pulse[3];

    assign terminal = (num_ms == 4'd9) && (num_us == 4'd9) &&
                      (num_ds == 4'd9) && (num_cs == 4'd9);

    state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PARADO: begin
                if (ev_zerar)       state_d = ZERANDO;
                else if (ev_contar) state_d = CONTANDO;
            end
            CONTANDO: begin
                if (ev_zerar)       state_d = ZERANDO;
                else if (terminal)  state_d = PARADO;
                else if (ev_parar)  state_d = PARADO;
                else if (ev_pausar) state_d = PAUSADO;
            end
            PAUSADO: begin
                if (ev_zerar)       state_d = ZERANDO;
                else if (ev_parar)  state_d = PARADO;
                else if (ev_contar) state_d = CONTANDO;
            end
            ZERANDO: state_d = PARADO;
            default: state_d = PARADO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= PARADO;
        end else begin
            state_q <= state_d;
        end
    end

    assign pararC  = (state_q == PARADO);
    assign contarC = (state_q == CONTANDO);
    assign pausarC = (state_q == PAUSADO);
    assign resetC  = (state_q == ZERANDO);
    assign estado  = state_q;

endmodule

// File: tb/tb_controle_entradas.sv
// Directed bench for controle_entradas with DEBOUNCE_CYCLES=4, checked every cycle
// against a sample-history model plus literal latency expectations.
module tb_controle_entradas;
    localparam int N = 4;

    logic       clock;
    logic       reset;
    logic       btn_contar, btn_pausar, btn_parar, btn_zerar;
    logic [3:0] num_ms, num_us, num_ds, num_cs;
    logic       resetC, contarC, pausarC, pararC;
    logic [1:0] estado;

    int tests = 0;
    int fails = 0;

    controle_entradas #(.DEBOUNCE_CYCLES(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_contar(btn_contar),
        .btn_pausar(btn_pausar),
        .btn_parar (btn_parar),
        .btn_zerar (btn_zerar),
        .num_ms    (num_ms),
        .num_us    (num_us),
        .num_ds    (num_ds),
        .num_cs    (num_cs),
        .resetC    (resetC),
        .contarC   (contarC),
        .pausarC   (pausarC),
        .pararC    (pararC),
        .estado    (estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: raw samples per edge; a level is accepted once the N samples that have
    // crossed the two-flop synchronizer all disagree with the current debounced level.
    // A rising acceptance acts on the state two edges later.
    bit hist [4][N+2];
    bit deb_m[4];
    bit sa_m [4];
    bit sb_m [4];
    int st_m;  // 0 parado, 1 contando, 2 pausado, 3 zerando

    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < N + 2; j++) hist[b][j] = 1'b0;
            deb_m[b] = 1'b0;
            sa_m[b]  = 1'b0;
            sb_m[b]  = 1'b0;
        end
        st_m = 0;
    endtask

    task automatic model_step();
        bit raw[4];
        bit ev[4];
        bit all_diff;
        bit term;
        raw[0] = btn_contar;
        raw[1] = btn_pausar;
        raw[2] = btn_parar;
        raw[3] = btn_zerar;
        term = (num_ms == 9) && (num_us == 9) && (num_ds == 9) && (num_cs == 9);
        for (int b = 0; b < 4; b++) begin
            ev[b]   = sb_m[b];
            sb_m[b] = sa_m[b];
            for (int j = N + 1; j > 0; j--) hist[b][j] = hist[b][j-1];
            hist[b][0] = raw[b];
            all_diff = 1'b1;
            for (int j = 2; j <= N + 1; j++) if (hist[b][j] == deb_m[b]) all_diff = 1'b0;
            sa_m[b] = 1'b0;
            if (all_diff) begin
                deb_m[b] = ~deb_m[b];
                sa_m[b]  = deb_m[b];
            end
        end
        if (st_m == 3)                  st_m = 0;
        else if (ev[3])                 st_m = 3;
        else if (st_m == 1 && term)     st_m = 0;
        else if (ev[2])                 st_m = 0;
        else if (ev[1]) begin
            if (st_m == 1) st_m = 2;
        end else if (ev[0]) begin
            if (st_m != 1) st_m = 1;
        end
    endtask

    always @(posedge clock) begin
        if (!reset) model_reset();
        else        model_step();
        #1;
        check("cyc_estado", int'(estado), st_m);
        check("cyc_outputs", int'({resetC, pausarC, contarC, pararC}),
              (st_m == 3 ? 8 : 0) + (st_m == 2 ? 4 : 0) + (st_m == 1 ? 2 : 0) + (st_m == 0 ? 1 : 0));
    end

    initial begin
        reset = 1'b0;
        {btn_contar, btn_pausar, btn_parar, btn_zerar} = 4'b0;
        {num_ms, num_us, num_ds, num_cs} = 16'h0;
        model_reset();

        repeat (3) @(negedge clock);
        check("rst_pararC", int'(pararC), 1);
        check("rst_others", int'({resetC, pausarC, contarC}), 0);
        check("rst_estado", int'(estado), 0);
        reset = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            check("idle_parado", int'({estado, pararC}), 1);
        end

        btn_contar = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 7) check("contar_edge7", int'(contarC), 0);
            if (i == 8) begin
                check("contar_edge8", int'(contarC), 1);
                check("contar_estado", int'(estado), 1);
            end
        end
        btn_contar = 1'b0;
        repeat (10) @(negedge clock);

        btn_pausar = 1'b1; @(negedge clock);
        btn_pausar = 1'b0; @(negedge clock);
        btn_pausar = 1'b1; @(negedge clock);
        btn_pausar = 1'b0; @(negedge clock);
        check("bounce_nochange", int'(contarC), 1);
        btn_pausar = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 7) check("pausar_edge7", int'(pausarC), 0);
            if (i == 8) begin
                check("pausar_edge8", int'(pausarC), 1);
                check("pausar_estado", int'(estado), 2);
            end
        end
        btn_pausar = 1'b0;
        repeat (10) @(negedge clock);

        btn_zerar  = 1'b1;
        btn_contar = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 7) check("zc_edge7_paused", int'(pausarC), 1);
            if (i == 8) check("zc_edge8_zerando", int'({estado, resetC}), 7);
            if (i == 9) check("zc_edge9_parado", int'({resetC, pararC}), 1);
            if (i == 10) check("zc_edge10_parado", int'(pararC), 1);
        end
        btn_zerar  = 1'b0;
        btn_contar = 1'b0;
        repeat (10) @(negedge clock);

        btn_contar = 1'b1;
        repeat (6) @(negedge clock);
        btn_contar = 1'b0;
        repeat (8) @(negedge clock);
        check("term_pre_contando", int'(contarC), 1);
        num_ms = 4'd9; num_us = 4'd9; num_ds = 4'd9; num_cs = 4'd10;
        @(negedge clock);
        check("term_9_9_9_10", int'(contarC), 1);
        num_cs = 4'd9;
        @(negedge clock);
        check("term_9999_parar", int'(pararC), 1);
        check("term_9999_estado", int'(estado), 0);
        {num_ms, num_us, num_ds, num_cs} = 16'h0;
        repeat (10) @(negedge clock);

        btn_contar = 1'b1;
        repeat (6) @(negedge clock);
        btn_contar = 1'b0;
        repeat (10) @(negedge clock);
        check("rstmid_contando", int'(contarC), 1);
        btn_parar = 1'b1;
        repeat (2) @(negedge clock);
        reset     = 1'b0;
        btn_parar = 1'b0;
        #1;
        check("rstmid_async_parar", int'(pararC), 1);
        check("rstmid_async_estado", int'(estado), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (12) @(negedge clock);
        check("rstmid_no_residual", int'(pararC), 1);

        btn_contar = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (i == 7) check("held_rst_edge7", int'(contarC), 0);
            if (i == 8) check("held_rst_edge8", int'(contarC), 1);
        end
        btn_contar = 1'b0;
        repeat (10) @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/controle_entradas.md
CONTROLE_ENTRADAS -- requirements
Module: controle_entradas

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, the number of consecutive stable cycles required to accept a button level change (legal range 2..2^20).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all flops on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port btn_contar, input, 1 bit: raw start/resume button, active-high, asynchronous to clock.
REQ-005 SHALL have port btn_pausar, input, 1 bit: raw pause button, active-high, asynchronous.
REQ-006 SHALL have port btn_parar, input, 1 bit: raw stop button, active-high, asynchronous.
REQ-007 SHALL have port btn_zerar, input, 1 bit: raw clear button, active-high, asynchronous.
REQ-008 SHALL have ports num_ms, num_us, num_ds, num_cs, input, 4 bits each: current BCD digits fed back from the counter chain.
REQ-009 SHALL have ports resetC, contarC, pausarC, pararC, output, 1 bit each: command levels to the counter chain.
REQ-010 SHALL have port estado, output, 2 bits: current FSM state code.

Function
REQ-011 SHALL pass each button through a two-flop synchronizer before any other logic.
REQ-012 SHALL keep, per button, a debounced level and a counter: while the synchronized level differs from the debounced level, the counter increments; when it reaches DEBOUNCE_CYCLES the debounced level takes the new value and the counter clears; any cycle with equal levels clears the counter.
REQ-013 SHALL generate a one-cycle press pulse on each 0->1 transition of a debounced level; 1->0 transitions produce no pulse.
REQ-014 SHALL implement states PARADO=00, CONTANDO=01, PAUSADO=10, ZERANDO=11.
REQ-015 SHALL resolve simultaneous pulses in this priority order: zerar, parar, pausar, contar; lower-priority pulses in that cycle are discarded.
REQ-016 SHALL transition from PARADO to CONTANDO on contar and to ZERANDO on zerar; pausar and parar are ignored in PARADO.
REQ-017 SHALL transition from CONTANDO to PAUSADO on pausar, to PARADO on parar, to ZERANDO on zerar, and to PARADO on terminal count; contar is ignored in CONTANDO.
REQ-018 SHALL define terminal count as num_ms, num_us, num_ds and num_cs all equal to 9; it is evaluated only in CONTANDO, with lower priority than zerar and higher priority than parar/pausar.
REQ-019 SHALL transition from PAUSADO to CONTANDO on contar, to PARADO on parar, and to ZERANDO on zerar.
REQ-020 SHALL hold ZERANDO for exactly one cycle and then enter PARADO unconditionally; pulses arriving in ZERANDO are discarded.
REQ-021 SHALL decode the outputs from the state register (Moore): pararC=1 in PARADO, contarC=1 in CONTANDO, pausarC=1 in PAUSADO, resetC=1 in ZERANDO, and SHALL keep exactly one of the four high at all times.
REQ-022 SHALL produce a latency of exactly DEBOUNCE_CYCLES+4 rising edges from the first edge sampling a clean 0->1 level to the corresponding state/output change.
REQ-023 SHALL treat BCD digits greater than 9 as not terminal.

Reset
REQ-024 SHALL, while reset=0, asynchronously clear all synchronizer flops, debounced levels, counters and pulses, and set the state to PARADO (pararC=1, others 0, estado=00).
REQ-025 SHALL recover synchronously on reset release; a button held through reset release SHALL register as a press after the normal REQ-022 latency.
REQ-026 SHALL, when reset is asserted mid-debounce or mid-ZERANDO, abandon that activity and leave no residual pulse.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 SHALL cover: after reset, with all buttons at 0 -> pararC=1, estado=00 for 20 cycles.
REQ-028 SHALL cover: btn_contar held high for 10 cycles -> contarC rises exactly 8 edges after the first sampling edge; estado=01.
REQ-029 SHALL cover: btn_pausar bouncing 1,0,1,0 on alternating cycles, then held -> no output change until 4 consecutive stable synchronized cycles; then pausarC=1.
REQ-030 SHALL cover: btn_zerar and btn_contar pressed together in PAUSADO -> resetC=1 for exactly one cycle, then pararC=1.
REQ-031 SHALL cover: in CONTANDO, digits driven to 9,9,9,9 -> pararC=1 on the next edge; digits 9,9,9,10 -> no change.
REQ-032 SHALL cover: reset pulled low 2 cycles into a debounce of btn_parar -> outputs return to PARADO immediately, and no parar pulse occurs after release unless the button is still held.
